// File: rtl/axis_arbiter_wrr_if.sv
// Arbiter request/grant bundle: per-port request, acknowledge and weight in, grant out.
// Latency: none, wires only.
// Backpressure: none; grant holds until a quantum event is observed by the arbiter.
interface axis_arbiter_wrr_if #(
   parameter int PORTS        = 4,
   parameter int WEIGHT_WIDTH = 4
);
   localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

   logic [PORTS-1:0]              request;
   logic [PORTS-1:0]              acknowledge;
   logic [PORTS*WEIGHT_WIDTH-1:0] weight;
   logic [PORTS-1:0]              grant;
   logic                          grant_valid;
   logic [IDX_W-1:0]              grant_encoded;

   // requester side: drives requests, observes the grant
   modport master (
      output request, acknowledge, weight,
      input  grant, grant_valid, grant_encoded
   );

   // arbiter side
   modport slave (
      input  request, acknowledge, weight,
      output grant, grant_valid, grant_encoded
   );
endinterface

// File: rtl/axis_arbiter_wrr.sv
// Weighted round-robin arbiter; optional per-port grant counters under AXIS_ARB_STATS_EN.
// Latency: eligible request in IDLE -> registered grant on the next clk edge.
// Backpressure: grant holds until a quantum event (every cycle, or acknowledge of granted port).
module axis_arbiter_wrr #(
   parameter int    PORTS        = 4,
   parameter int    WEIGHT_WIDTH = 4,
   parameter string BLOCK        = "ACKNOWLEDGE",
   parameter string LSB_PRIORITY = "LOW"
) (
   input logic                clk,
   input logic                rst,
   axis_arbiter_wrr_if.slave  arb
`ifdef AXIS_ARB_STATS_EN
   ,
   output logic [PORTS*16-1:0] stat_grants
`endif
);
   localparam int IDX_W      = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam bit ACK_MODE   = (BLOCK == "ACKNOWLEDGE");
   localparam bit HIGH_FIRST = (LSB_PRIORITY == "HIGH");
   // pointer value whose "next" in rotation order is the preferred first port
   localparam logic [IDX_W-1:0] PTR_RESET = HIGH_FIRST ? '0 : IDX_W'(PORTS - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                  state, state_nxt;
   logic [WEIGHT_WIDTH-1:0] credit, credit_nxt;
   logic [IDX_W-1:0]        last_idx, last_nxt;
   logic [PORTS-1:0]        grant_nxt;
   logic [IDX_W-1:0]        enc_nxt;

   logic [PORTS-1:0]        eligible;
   logic                    any_elig;
   logic [IDX_W-1:0]        win_idx;
   logic [WEIGHT_WIDTH-1:0] win_weight;
   logic                    cur_req;
   logic                    cur_ack;
   logic                    quantum;
   logic                    issue;
   logic                    consume;
   int                      cand;
   logic [IDX_W-1:0]        cand_idx;

   // a port competes only when it requests and is not disabled by a zero weight
   always_comb begin
      eligible = '0;
      for (int i = 0; i < PORTS; i++) begin
         eligible[i] = arb.request[i] && (arb.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
      end
   end

   assign any_elig = |eligible;
   assign cur_req  = arb.request[arb.grant_encoded];
   assign cur_ack  = arb.acknowledge[arb.grant_encoded];
   assign quantum  = ACK_MODE ? cur_ack : 1'b1;

   // rotation search: nearest eligible port after last_idx; last_idx itself is the final candidate
   always_comb begin
      win_idx  = last_idx;
      cand     = 0;
      cand_idx = '0;
      for (int k = PORTS; k >= 1; k--) begin
         if (HIGH_FIRST) cand = (int'(last_idx) + PORTS - k) % PORTS;
         else            cand = (int'(last_idx) + k) % PORTS;
         cand_idx = IDX_W'(cand);
         if (eligible[cand_idx]) win_idx = cand_idx;
      end
   end

   // weight of the winner, sampled only when a new grant loads credit
   always_comb begin
      win_weight = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (IDX_W'(i) == win_idx) win_weight = arb.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
   end

   // next-state: decide between issuing a new grant, consuming credit, holding or idling
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      consume   = 1'b0;
      case (state)
         IDLE: begin
            if (any_elig) begin
               state_nxt = GRANT;
               issue     = 1'b1;
            end
         end
         GRANT: begin
            if (quantum) begin
               if (credit != '0 && cur_req) consume = 1'b1;
               else if (any_elig)            issue   = 1'b1;
               else                          state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // output/datapath next values, registered below so every output is a flop
   always_comb begin
      grant_nxt  = arb.grant;
      enc_nxt    = arb.grant_encoded;
      credit_nxt = credit;
      last_nxt   = last_idx;
      if (issue) begin
         grant_nxt          = '0;
         grant_nxt[win_idx] = 1'b1;
         enc_nxt            = win_idx;
         credit_nxt         = win_weight - WEIGHT_WIDTH'(1);
         last_nxt           = win_idx;
      end else if (consume) begin
         credit_nxt = credit - WEIGHT_WIDTH'(1);
      end else if (state_nxt == IDLE) begin
         grant_nxt  = '0;
         enc_nxt    = '0;
         credit_nxt = '0;
      end
   end

   // state and output registers; reset also restarts the rotation pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         credit            <= '0;
         last_idx          <= PTR_RESET;
         arb.grant         <= '0;
         arb.grant_valid   <= 1'b0;
         arb.grant_encoded <= '0;
      end else begin
         state             <= state_nxt;
         credit            <= credit_nxt;
         last_idx          <= last_nxt;
         arb.grant         <= grant_nxt;
         arb.grant_valid   <= (state_nxt == GRANT);
         arb.grant_encoded <= enc_nxt;
      end
   end

`ifdef AXIS_ARB_STATS_EN
   logic [15:0] stat_cnt [PORTS];

   // count every newly issued grant per port, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PORTS; i++) stat_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (issue && win_idx == IDX_W'(i) && stat_cnt[i] != 16'hFFFF)
               stat_cnt[i] <= stat_cnt[i] + 16'd1;
         end
      end
   end

   for (genvar g = 0; g < PORTS; g++) begin : g_stat
      assign stat_grants[g*16 +: 16] = stat_cnt[g];
   end
`endif

endmodule
